// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit.
// Multiplies and divides work on operand magnitudes over 32 single-bit iterations;
// sign correction is applied once in the final state. Divide-by-zero and signed
// overflow are resolved at accept time and complete in a single cycle.
module alu_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  state_e      r_state;
  logic [5:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic        r_sign_a;
  logic        r_sign_b;
  // Multiplicand for multiplies, divisor for divides.
  logic [31:0] r_opnd;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [63:0] r_acc;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;

  logic        w_is_div;
  logic        w_signed_a;
  logic        w_signed_b;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_special;
  logic [31:0] w_special_res;

  // Decode the incoming request: signedness, magnitudes and special divide cases.
  always_comb begin
    w_is_div   = i_funct3[2];
    w_signed_a = (i_funct3 == OpMulh) || (i_funct3 == OpMulhsu) ||
                 (i_funct3 == OpDiv)  || (i_funct3 == OpRem);
    w_signed_b = (i_funct3 == OpMulh) || (i_funct3 == OpDiv) || (i_funct3 == OpRem);
    w_neg_a    = w_signed_a & i_op_a[31];
    w_neg_b    = w_signed_b & i_op_b[31];
    w_mag_a    = w_neg_a ? (~i_op_a + 32'd1) : i_op_a;
    w_mag_b    = w_neg_b ? (~i_op_b + 32'd1) : i_op_b;
    w_div_zero = w_is_div && (i_op_b == 32'd0);
    w_div_ovf  = w_is_div && !i_funct3[0] &&
                 (i_op_a == 32'h8000_0000) && (i_op_b == 32'hFFFF_FFFF);
    w_special  = w_div_zero || w_div_ovf;
    if (w_div_zero) begin
      w_special_res = i_funct3[1] ? i_op_a : 32'hFFFF_FFFF;
    end else begin
      w_special_res = i_funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_diff;
  logic [63:0] w_div_next;
  logic [63:0] w_acc_next;

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};
    w_mul_next  = {w_mul_sum, r_acc[31:1]};
    w_div_shift = {r_acc[63:32], r_acc[31]};
    w_div_diff  = w_div_shift - {1'b0, r_opnd};
    if (w_div_diff[32]) begin
      w_div_next = {w_div_shift[31:0], r_acc[30:0], 1'b0};
    end else begin
      w_div_next = {w_div_diff[31:0], r_acc[30:0], 1'b1};
    end
    w_acc_next = r_funct3[2] ? w_div_next : w_mul_next;
  end

  logic        w_res_neg;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_fin_res;

  // Sign correction and result selection for the completing operation.
  always_comb begin
    w_res_neg = r_sign_a ^ r_sign_b;
    w_prod    = w_res_neg ? (~r_acc + 64'd1) : r_acc;
    w_quo     = w_res_neg ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    w_rem     = r_sign_a ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    case (r_funct3)
      OpMul:                    w_fin_res = w_prod[31:0];
      OpMulh, OpMulhsu, OpMulhu: w_fin_res = w_prod[63:32];
      OpDiv, OpDivu:            w_fin_res = w_quo;
      OpRem, OpRemu:            w_fin_res = w_rem;
      default:                  w_fin_res = 32'd0;
    endcase
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= 6'd0;
      r_funct3 <= 3'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opnd   <= 32'd0;
      r_acc    <= 64'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start && !i_flush) begin
            r_funct3 <= i_funct3;
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
            if (w_special) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
            end else begin
              r_state <= StCalc;
              r_busy  <= 1'b1;
              r_cnt   <= 6'd0;
              if (w_is_div) begin
                r_opnd <= w_mag_b;
                r_acc  <= {32'd0, w_mag_a};
              end else begin
                r_opnd <= w_mag_a;
                r_acc  <= {32'd0, w_mag_b};
              end
            end
          end
        end
        StCalc: begin
          if (i_flush) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_cnt   <= 6'd0;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) begin
              r_state <= StFin;
            end
          end
        end
        StFin: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_cnt   <= 6'd0;
          if (!i_flush) begin
            r_result <= w_fin_res;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_cnt   <= 6'd0;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv: directed vectors with literal expectations, plus a
// cycle-level behavioural model compared against the DUT on every falling edge.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  alu_muldiv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (start),
    .i_funct3 (funct3),
    .i_op_a   (op_a),
    .i_op_b   (op_b),
    .i_flush  (flush),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  // RV32M result computed with plain 64-bit / 32-bit arithmetic.
  function automatic logic [31:0] model_res(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = 32'd0;
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Cycle-level model: countdown of remaining edges until the pending result appears.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pend = 32'd0;
  int          m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_result <= 32'd0;
      m_left   <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (flush) begin
          m_left <= 0;
          m_busy <= 1'b0;
        end else if (m_left == 1) begin
          m_left   <= 0;
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          m_result <= m_pend;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start && !flush) begin
        if (is_special(funct3, op_a, op_b)) begin
          m_done   <= 1'b1;
          m_result <= model_res(funct3, op_a, op_b);
        end else begin
          m_pend <= model_res(funct3, op_a, op_b);
          m_left <= 33;
          m_busy <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    chk("model busy", 64'(busy), 64'(m_busy));
    chk("model done", 64'(done), 64'(m_done));
    chk("model result", 64'(result), 64'(m_result));
  end

  logic [31:0] last_res = 32'd0;

  // Issue one op from a falling edge; wait for done; check literal result, latency, busy span.
  // poke > 0 pulses an extra (ignored) start that many cycles after accept.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int poke);
    int k;
    int nb;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk);
    #2;
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    funct3 = 3'($urandom);
    k  = 0;
    nb = 0;
    @(negedge clk);
    while (!done && k < 40) begin
      if (busy) nb++;
      if (poke > 0 && k == poke) begin
        start  = 1'b1;
        funct3 = 3'd4;
        op_a   = 32'd100;
        op_b   = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (k >= 40) chk({nm, " timeout"}, 64'(k), 64'(exp_lat));
    chk(nm, 64'(result), 64'(exp));
    chk({nm, " latency"}, 64'(k), 64'(exp_lat));
    chk({nm, " busy cycles"}, 64'(nb), (exp_lat == 0) ? 64'd0 : 64'd33);
    last_res = exp;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("MULHU -1*-1",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("MULH -1*-1",      3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33, 0);
    run_op("MULHSU -1*ffff",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op("MULH min*min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("MULHSU min*2^31", 3'd2, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, 33, 0);
    run_op("MUL 0*-5",        3'd0, 32'd0,          32'hFFFF_FFFB, 32'h0000_0000, 33, 0);
    run_op("DIV 100/0",       3'd4, 32'd100,        32'd0,         32'hFFFF_FFFF, 0,  0);
    run_op("REMU 100/0",      3'd7, 32'd100,        32'd0,         32'd100,       0,  0);
    run_op("DIV ovf",         3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0,  0);
    run_op("REM ovf",         3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 0,  0);
    run_op("DIV -7/2",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 0);
    run_op("REM -7/2",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("DIVU fff9/2",     3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 33, 0);
    run_op("DIV 7/-2",        3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run_op("REM 7/-2",        3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33, 0);
    run_op("MUL poked",       3'd0, 32'd7,          32'd3,         32'd21,        33, 4);

    // Flush ten cycles into a multiply.
    funct3 = 3'd0;
    op_a   = 32'd5;
    op_b   = 32'd6;
    start  = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    flush = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    @(negedge clk);
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush done", 64'(done), 64'd0);
    chk("flush result", 64'(result), 64'(last_res));
    repeat (3) @(negedge clk);
    run_op("DIVU 9/3", 3'd5, 32'd9, 32'd3, 32'd3, 33, 0);

    // start together with flush in idle is dropped.
    funct3 = 3'd4;
    op_b   = 32'd0;
    start  = 1'b1;
    flush  = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("start+flush done", 64'(done), 64'd0);
    chk("start+flush busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a calculation.
    run_op("MUL 3*3", 3'd0, 32'd3, 32'd3, 32'd9, 33, 0);
    funct3 = 3'd0;
    op_a   = 32'd11;
    op_b   = 32'd13;
    start  = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst done", 64'(done), 64'd0);
    chk("async rst result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("MULHU 2^31*2", 3'd3, 32'h8000_0000, 32'd2, 32'd1, 33, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
